// File: rtl/ctta_driver.sv
// Sequential front end for the 4-bit add/subtract unit: drives operands,
// captures and decodes the 5-bit result, and queues responses in a FIFO.
module ctta_driver #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_op,
    input  logic [3:0]       cmd_a,
    input  logic [3:0]       cmd_b,
    output logic [3:0]       alu_a,
    output logic [3:0]       alu_b,
    output logic [3:0]       alu_c,
    output logic             alu_ctrl,
    output logic             alu_rst,
    input  logic [4:0]       alu_q,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [3:0]       rsp_sum,
    output logic             rsp_flag,
    output logic             rsp_zero,
    output logic             rsp_op,
    output logic             err,
    output logic [CNT_W-1:0] ops_done
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        CAPTURE
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [6:0]    mem [DEPTH];
    logic [6:0]    head;
    logic [6:0]    entry;
    logic          armed;
    logic          accept;
    logic          push;
    logic          pop;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = DRIVE;
            DRIVE:   state_nx = CAPTURE;
            CAPTURE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign cmd_ready = (state == IDLE) && (count < (AW+1)'(DEPTH)) && !rst;
    assign accept    = cmd_valid && cmd_ready;
    assign push      = (state == CAPTURE);
    assign pop       = rsp_valid && rsp_ready;
    assign alu_rst   = (state == IDLE);

    // Entry layout: {op, zero, flag, sum}
    assign entry = {alu_ctrl, alu_q[3:0] == 4'd0, alu_q[4], alu_q[3:0]};
    assign head  = mem[rd_ptr];

    assign rsp_valid = (count != '0);
    assign rsp_sum   = rsp_valid ? head[3:0] : 4'd0;
    assign rsp_flag  = rsp_valid && head[4];
    assign rsp_zero  = rsp_valid && head[5];
    assign rsp_op    = rsp_valid && head[6];

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            alu_a    <= 4'd0;
            alu_b    <= 4'd0;
            alu_c    <= 4'd0;
            alu_ctrl <= 1'b0;
        end else if (accept) begin
            alu_a    <= cmd_a;
            alu_ctrl <= cmd_op;
            alu_b    <= cmd_op ? 4'd0 : cmd_b;
            alu_c    <= cmd_op ? cmd_b : 4'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= entry;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            ops_done <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
            if (push) ops_done <= ops_done + CNT_W'(1);
        end
    end

    // The unit is held in clear while idle, so any nonzero result there is a fault.
    always_ff @(posedge clk) begin
        if (rst) begin
            armed <= 1'b0;
            err   <= 1'b0;
        end else begin
            armed <= 1'b1;
            if (state == IDLE && armed && alu_q != 5'd0) err <= 1'b1;
        end
    end

endmodule
